// File: rtl/m2014_q6_state_reg.sv
// Six-state Moore FSM (A..F) stepped by w_valid, with a saturating count of entries into F.
// Optional F-entry counter enabled by defining M2014_Q6_HIT_CNT_EN; otherwise hit_cnt is tied to 0.
module m2014_q6_state_reg #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             w,
  input  logic             w_valid,
  input  logic             clr,
  output logic [2:0]       y,
  output logic             z,
  output logic [CNT_W-1:0] hit_cnt
);

  typedef enum logic [2:0] {
    ST_A = 3'b000,
    ST_B = 3'b001,
    ST_C = 3'b010,
    ST_D = 3'b011,
    ST_E = 3'b100,
    ST_F = 3'b101
  } state_t;

  state_t state_reg;

  // Bit 1 of this table reproduces the upstream Y1 equation:
  // Y1 = B | (w & (C | E | F)) | (~w & F).
  // Codes 110/111 are unreachable in normal operation and recover to A.
  function automatic state_t next_state(input state_t cur, input logic win);
    case (cur)
      ST_A:    next_state = win ? ST_A : ST_B;
      ST_B:    next_state = win ? ST_D : ST_C;
      ST_C:    next_state = win ? ST_D : ST_E;
      ST_D:    next_state = win ? ST_A : ST_F;
      ST_E:    next_state = win ? ST_D : ST_E;
      ST_F:    next_state = win ? ST_D : ST_C;
      default: next_state = ST_A;
    endcase
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_A;
    end else if (w_valid) begin
      state_reg <= next_state(state_reg, w);
    end
  end

  // z decodes only the state register, so w/w_valid/clr never reach an output combinationally.
  assign y = state_reg;
  assign z = (state_reg == ST_E) || (state_reg == ST_F);

`ifdef M2014_Q6_HIT_CNT_EN
  logic             f_entry;
  logic [CNT_W-1:0] hit_cnt_reg;

  assign f_entry = w_valid && (state_reg != ST_F) && (next_state(state_reg, w) == ST_F);

  // clr outranks a simultaneous entry; the count sticks at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_cnt_reg <= '0;
    end else if (clr) begin
      hit_cnt_reg <= '0;
    end else if (f_entry && (hit_cnt_reg != {CNT_W{1'b1}})) begin
      hit_cnt_reg <= hit_cnt_reg + 1'b1;
    end
  end

  assign hit_cnt = hit_cnt_reg;
`else
  logic unused_clr;

  assign unused_clr = clr;
  assign hit_cnt    = '0;
`endif

endmodule

// File: tb/tb_m2014_q6_state_reg.sv
// Directed bench for m2014_q6_state_reg: two instances (CNT_W=8 and CNT_W=2) share one stimulus.
// Expected hit_cnt values follow M2014_Q6_HIT_CNT_EN (all zero when the counter is compiled out).
module tb_m2014_q6_state_reg;

`ifdef M2014_Q6_HIT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       w = 1'b0;
  logic       w_valid = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] y8, y2;
  logic       z8, z2;
  logic [7:0] hit8;
  logic [1:0] hit2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m2014_q6_state_reg u_dut8 (
    .clk(clk), .resetn(resetn), .w(w), .w_valid(w_valid), .clr(clr),
    .y(y8), .z(z8), .hit_cnt(hit8)
  );

  m2014_q6_state_reg #(.CNT_W(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .w(w), .w_valid(w_valid), .clr(clr),
    .y(y2), .z(z2), .hit_cnt(hit2)
  );

  // One clock edge with the given inputs; outputs are stable 1 time unit later.
  task automatic step(input logic wv, input logic wb, input logic c);
    w = wb; w_valid = wv; clr = c;
    @(posedge clk);
    #1;
    w_valid = 1'b0; clr = 1'b0;
    $display("[%0t] step w_valid=%0b w=%0b clr=%0b -> y=%b z=%0b hit8=%0d hit2=%0d",
             $time, wv, wb, c, y8, z8, hit8, hit2);
  endtask

  // Asynchronous pulse placed between edges (caller sits 1 unit after a posedge).
  task automatic do_reset();
    resetn = 1'b0;
    #3;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    #2;
    checks++;
    if (y8 !== 3'b000 || z8 !== 1'b0 || hit8 !== 8'd0 || hit2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: got y=%b z=%b hit8=%0d hit2=%0d exp y=000 z=0 hit=0", y8, z8, hit8, hit2);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (y8 !== 3'b000 || y2 !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_hold: got y8=%b y2=%b exp 000", y8, y2);
    end
  endtask

  task automatic test_abc();
    logic [2:0] exp_y[3];
    logic       exp_z[3];
    exp_y = '{3'b001, 3'b010, 3'b100};
    exp_z = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (y8 !== exp_y[i] || z8 !== exp_z[i] || y2 !== exp_y[i]) begin
        errors++;
        $display("FAIL abc_step%0d: got y=%b z=%b exp y=%b z=%b", i, y8, z8, exp_y[i], exp_z[i]);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, i[0], 1'b0);
      checks++;
      if (y8 !== 3'b010 || z8 !== 1'b0) begin
        errors++;
        $display("FAIL hold_c%0d: got y=%b z=%b exp y=010 z=0", i, y8, z8);
      end
    end
  endtask

  task automatic test_f_entry();
    logic [2:0] exp_y[3];
    logic       exp_w[3];
    logic [7:0] exp_hit;
    exp_y = '{3'b001, 3'b011, 3'b101};
    exp_w = '{1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, exp_w[i], 1'b0);
      checks++;
      if (y8 !== exp_y[i]) begin
        errors++;
        $display("FAIL f_entry_y%0d: got %b exp %b", i, y8, exp_y[i]);
      end
    end
    exp_hit = CNT_EN ? 8'd1 : 8'd0;
    checks++;
    if (z8 !== 1'b1 || hit8 !== exp_hit || hit2 !== exp_hit[1:0]) begin
      errors++;
      $display("FAIL f_entry_out: got z=%b hit8=%0d hit2=%0d exp z=1 hit=%0d", z8, hit8, hit2, exp_hit);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] exp8;
    logic [1:0] exp2;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (y8 !== 3'b011) begin
          errors++;
          $display("FAIL sat_to_d%0d: got y=%b exp 011", k, y8);
        end
      end
      step(1'b1, 1'b0, 1'b0);
      exp8 = CNT_EN ? 8'(k) : 8'd0;
      exp2 = CNT_EN ? ((k > 3) ? 2'd3 : 2'(k)) : 2'd0;
      checks++;
      if (y8 !== 3'b101 || hit8 !== exp8 || hit2 !== exp2) begin
        errors++;
        $display("FAIL sat_entry%0d: got y=%b hit8=%0d hit2=%0d exp y=101 hit8=%0d hit2=%0d",
                 k, y8, hit8, hit2, exp8, exp2);
      end
    end
  endtask

  task automatic test_clr_priority();
    logic [7:0] exp8;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end
    exp8 = CNT_EN ? 8'd4 : 8'd0;
    checks++;
    if (hit8 !== exp8) begin
      errors++;
      $display("FAIL clr_precount: got hit8=%0d exp %0d", hit8, exp8);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (y8 !== 3'b101 || z8 !== 1'b1 || hit8 !== 8'd0 || hit2 !== 2'd0) begin
      errors++;
      $display("FAIL clr_vs_entry: got y=%b z=%b hit8=%0d hit2=%0d exp y=101 z=1 hit=0", y8, z8, hit8, hit2);
    end
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (y8 !== 3'b101 || z8 !== 1'b1 || hit8 !== 8'd0) begin
      errors++;
      $display("FAIL clr_no_state_effect: got y=%b z=%b hit8=%0d exp y=101 z=1 hit=0", y8, z8, hit8);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    exp8 = CNT_EN ? 8'd1 : 8'd0;
    checks++;
    if (hit8 !== exp8 || hit2 !== exp8[1:0]) begin
      errors++;
      $display("FAIL clr_recount: got hit8=%0d hit2=%0d exp %0d", hit8, hit2, exp8);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp8;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    exp8 = CNT_EN ? 8'd2 : 8'd0;
    checks++;
    if (y8 !== 3'b100 || hit8 !== exp8) begin
      errors++;
      $display("FAIL areset_setup: got y=%b hit8=%0d exp y=100 hit8=%0d", y8, hit8, exp8);
    end
    #2 resetn = 1'b0;
    w = 1'b0; w_valid = 1'b1;
    #1;
    checks++;
    if (y8 !== 3'b000 || z8 !== 1'b0 || hit8 !== 8'd0 || hit2 !== 2'd0) begin
      errors++;
      $display("FAIL areset_immediate: got y=%b z=%b hit8=%0d hit2=%0d exp y=000 z=0 hit=0", y8, z8, hit8, hit2);
    end
    #1 resetn = 1'b1;
    w_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (y8 !== 3'b000) begin
      errors++;
      $display("FAIL areset_hold: got y=%b exp 000", y8);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_y[8];
    logic       exp_w[8];
    // A -w0-> B -w1-> D -w1-> A -w1-> A -w0-> B -w0-> C -w1-> D -w0-> F
    exp_w = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_y = '{3'b001, 3'b011, 3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, exp_w[i], 1'b0);
      checks++;
      if (y8 !== exp_y[i]) begin
        errors++;
        $display("FAIL b2b_step%0d: got y=%b exp %b", i, y8, exp_y[i]);
      end
    end
    // F -w0-> C -w0-> E -w0-> E -w1-> D
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_y = '{3'b010, 3'b100, 3'b100, 3'b011, 3'b101, 3'b010, 3'b100, 3'b100};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, exp_w[i], 1'b0);
      checks++;
      if (y8 !== exp_y[i] || z8 !== (exp_y[i] == 3'b100 || exp_y[i] == 3'b101)) begin
        errors++;
        $display("FAIL b2b_tail%0d: got y=%b z=%b exp y=%b", i, y8, z8, exp_y[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_hold();
    test_f_entry();
    test_saturate();
    test_clr_priority();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
